// File: rtl/sokoban_pkg.sv
// rtl/sokoban_pkg.sv - shared field ranges, widths and FSM encoding for the Sokoban controller
package sokoban_pkg;

   localparam int WAY_HI  = 133;
   localparam int WAY_LO  = 70;
   localparam int BOX_HI  = 69;
   localparam int BOX_LO  = 6;
   localparam int MAN_W   = 6;
   localparam int STATE_W = 134;
   localparam int GRID_W  = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_CHECK = 2'd2,
      ST_WON   = 2'd3
   } ctrl_state_e;

   // A level is solved when it has at least one goal and every goal cell holds a box.
   function automatic logic goal_met(input logic [GRID_W-1:0] goal,
                                     input logic [GRID_W-1:0] box);
      return ((goal & ~box) == '0) && (goal != '0);
   endfunction

endpackage

// File: rtl/game_man_move.sv
// rtl/game_man_move.sv - combinational single-step man mover with box push
module game_man_move
   import sokoban_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   input  logic [MAN_W-1:0]   cursor,
   output logic               result,
   output logic [STATE_W-1:0] state_next
);

   logic [GRID_W-1:0] way;
   logic [GRID_W-1:0] box;
   logic [GRID_W-1:0] box_next;
   logic [2:0]        man_y, man_x;
   logic [2:0]        cur_y, cur_x;
   logic [2:0]        dy, dx;
   logic [2:0]        t1_y, t1_x, t2_y, t2_x;
   logic [5:0]        t1, t2;
   logic              same;

   // One step toward the cursor: horizontal first, vertical once the column matches.
   // Neighbour arithmetic is 3-bit and wraps; levels keep the man off the border.
   always_comb begin
      way      = state[WAY_HI:WAY_LO];
      box      = state[BOX_HI:BOX_LO];
      man_y    = state[5:3];
      man_x    = state[2:0];
      cur_y    = cursor[5:3];
      cur_x    = cursor[2:0];
      dy       = 3'd0;
      dx       = 3'd0;
      same     = 1'b0;
      if (cur_x > man_x)      dx = 3'd1;
      else if (cur_x < man_x) dx = 3'd7;
      else if (cur_y > man_y) dy = 3'd1;
      else if (cur_y < man_y) dy = 3'd7;
      else                    same = 1'b1;
      t1_y     = man_y + dy;
      t1_x     = man_x + dx;
      t2_y     = t1_y + dy;
      t2_x     = t1_x + dx;
      t1       = {t1_y, t1_x};
      t2       = {t2_y, t2_x};
      box_next = box;
      result     = 1'b0;
      state_next = state;
      if (!same && way[t1]) begin
         if (!box[t1]) begin
            result     = 1'b1;
            state_next = {way, box, t1};
         end else if (way[t2] && !box[t2]) begin
            box_next[t1] = 1'b0;
            box_next[t2] = 1'b1;
            result       = 1'b1;
            state_next   = {way, box_next, t1};
         end
      end
   end

endmodule

// File: rtl/sokoban_game_ctrl.sv
// rtl/sokoban_game_ctrl.sv - game state sequencer with load, move, one-level undo and win detect
module sokoban_game_ctrl
   import sokoban_pkg::*;
#(
   parameter int STEP_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               level_load,
   input  logic [STATE_W-1:0] level_state,
   input  logic [GRID_W-1:0]  level_goal,
   input  logic               move_req,
   input  logic [MAN_W-1:0]   cursor,
   input  logic               undo_req,
   output logic [STATE_W-1:0] game_state,
   output logic [STEP_W-1:0]  step_count,
   output logic               busy,
   output logic               done,
   output logic               ok,
   output logic               won
);

   ctrl_state_e        state_q, state_d;
   logic [GRID_W-1:0]  goal_q;
   logic [MAN_W-1:0]   cur_q;
   logic [STATE_W-1:0] snap_q;
   logic               undo_vld;
   logic               mv_result;
   logic [STATE_W-1:0] mv_next;
   logic               win_now;

   logic do_load, do_capture, do_commit, do_undo, chk_en;
   logic done_d, ok_d;

   game_man_move u_mover (
      .state      (game_state),
      .cursor     (cur_q),
      .result     (mv_result),
      .state_next (mv_next)
   );

   assign win_now = goal_met(goal_q, game_state[BOX_HI:BOX_LO]);
   assign busy    = (state_q == ST_EVAL) || (state_q == ST_CHECK);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and datapath strobes; load overrides everything. Requests are
   // ignored in the cycle done is high so done can never pulse back to back.
   always_comb begin
      state_d    = state_q;
      do_load    = 1'b0;
      do_capture = 1'b0;
      do_commit  = 1'b0;
      do_undo    = 1'b0;
      chk_en     = 1'b0;
      done_d     = 1'b0;
      ok_d       = 1'b0;
      if (level_load) begin
         do_load = 1'b1;
         state_d = ST_CHECK;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!done) begin
                  if (undo_req) begin
                     done_d = 1'b1;
                     if (undo_vld) begin
                        do_undo = 1'b1;
                        ok_d    = 1'b1;
                        state_d = ST_CHECK;
                     end
                  end else if (move_req) begin
                     if (cursor == game_state[MAN_W-1:0]) begin
                        done_d = 1'b1;
                     end else begin
                        do_capture = 1'b1;
                        state_d    = ST_EVAL;
                     end
                  end
               end
            end
            ST_EVAL: begin
               done_d = 1'b1;
               if (mv_result) begin
                  do_commit = 1'b1;
                  ok_d      = 1'b1;
                  state_d   = ST_CHECK;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CHECK: begin
               chk_en  = 1'b1;
               state_d = win_now ? ST_WON : ST_IDLE;
            end
            ST_WON:  state_d = ST_WON;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Committed game state, goal map, undo snapshot, step counter and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         game_state <= '0;
         goal_q     <= '0;
         cur_q      <= '0;
         snap_q     <= '0;
         undo_vld   <= 1'b0;
         step_count <= '0;
         won        <= 1'b0;
         done       <= 1'b0;
         ok         <= 1'b0;
      end else begin
         done <= done_d;
         ok   <= ok_d;
         if (do_load) begin
            game_state <= level_state;
            goal_q     <= level_goal;
            step_count <= '0;
            undo_vld   <= 1'b0;
            won        <= 1'b0;
         end else begin
            if (do_capture) cur_q <= cursor;
            if (do_commit) begin
               snap_q     <= game_state;
               undo_vld   <= 1'b1;
               game_state <= mv_next;
               if (step_count != '1) step_count <= step_count + 1'b1;
            end
            if (do_undo) begin
               game_state <= snap_q;
               undo_vld   <= 1'b0;
               if (step_count != '0) step_count <= step_count - 1'b1;
            end
            if (chk_en) won <= win_now;
         end
      end
   end

endmodule

// File: tb/tb_sokoban_game_ctrl.sv
// tb/tb_sokoban_game_ctrl.sv - randomized self-checking bench for sokoban_game_ctrl
module tb_sokoban_game_ctrl;

   localparam int SW   = 3;
   localparam int SMAX = 7;
   localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         level_load = 1'b0;
   logic [133:0] level_state = '0;
   logic [63:0]  level_goal = '0;
   logic         move_req = 1'b0;
   logic [5:0]   cursor = '0;
   logic         undo_req = 1'b0;
   logic [133:0] game_state;
   logic [SW-1:0] step_count;
   logic         busy, done, ok, won;

   int checks = 0;
   int failures = 0;

   logic [133:0] m_state = '0;
   logic [133:0] m_snap = '0;
   logic [63:0]  m_goal = '0;
   bit           m_snap_v = 0;
   int           m_step = 0;
   bit           m_won = 0;

   sokoban_game_ctrl #(.STEP_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .level_load(level_load), .level_state(level_state),
      .level_goal(level_goal), .move_req(move_req), .cursor(cursor), .undo_req(undo_req),
      .game_state(game_state), .step_count(step_count), .busy(busy), .done(done),
      .ok(ok), .won(won)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic bit win(input logic [63:0] g, input logic [63:0] b);
      return (g != 0) && ((g & b) == g);
   endfunction

   function automatic logic [133:0] mk(input logic [63:0] w, input logic [63:0] b,
                                       input int y, input int x);
      return {w, b, 3'(y), 3'(x)};
   endfunction

   // Step one cell toward the cursor (column first), pushing a single box if there is room.
   function automatic logic [134:0] ref_move(input logic [133:0] s, input logic [5:0] c);
      logic [63:0] w, b;
      int my, mx, cy, cx, dy, dx, y1, x1, y2, x2, i1, i2;
      w = s[133:70]; b = s[69:6];
      my = int'(s[5:3]); mx = int'(s[2:0]); cy = int'(c[5:3]); cx = int'(c[2:0]);
      dy = 0; dx = 0;
      if (cx > mx) dx = 1;
      else if (cx < mx) dx = -1;
      else if (cy > my) dy = 1;
      else if (cy < my) dy = -1;
      else return {1'b0, s};
      y1 = (my + dy + 8) % 8; x1 = (mx + dx + 8) % 8;
      y2 = (y1 + dy + 8) % 8; x2 = (x1 + dx + 8) % 8;
      i1 = y1 * 8 + x1; i2 = y2 * 8 + x2;
      if (!w[i1]) return {1'b0, s};
      if (!b[i1]) return {1'b1, mk(w, b, y1, x1)};
      if (w[i2] && !b[i2]) begin
         b[i1] = 1'b0;
         b[i2] = 1'b1;
         return {1'b1, mk(w, b, y1, x1)};
      end
      return {1'b0, s};
   endfunction

   task automatic do_load(input logic [133:0] s, input logic [63:0] g);
      @(negedge clk);
      level_load = 1'b1; level_state = s; level_goal = g;
      @(negedge clk);
      level_load = 1'b0;
      m_state = s; m_goal = g; m_snap_v = 0; m_step = 0; m_won = win(g, s[69:6]);
      checks++;
      if (game_state !== m_state || step_count !== SW'(0) || won !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL load_commit state=%h step=%0d won=%b done=%b want state=%h step=0 won=0 done=0",
                  game_state, step_count, won, done, m_state);
      end
      @(negedge clk);
      checks++;
      if (won !== m_won) begin
         failures++;
         $display("FAIL load_won got=%b want=%b", won, m_won);
      end
   endtask

   task automatic do_req(input bit is_undo, input logic [5:0] cur);
      int exp_lat, got_lat, n_done;
      bit exp_ok, got_ok;
      logic [134:0] r;
      exp_lat = 0; exp_ok = 0; got_lat = 0; n_done = 0; got_ok = 0;
      if (!m_won) begin
         if (is_undo) begin
            exp_lat = 1;
            if (m_snap_v) begin
               exp_ok = 1; m_state = m_snap; m_snap_v = 0;
               if (m_step > 0) m_step--;
               m_won = win(m_goal, m_state[69:6]);
            end
         end else if (cur == m_state[5:0]) begin
            exp_lat = 1;
         end else begin
            exp_lat = 2;
            r = ref_move(m_state, cur);
            if (r[134]) begin
               exp_ok = 1; m_snap = m_state; m_snap_v = 1; m_state = r[133:0];
               if (m_step < SMAX) m_step++;
               m_won = win(m_goal, m_state[69:6]);
            end
         end
      end
      @(negedge clk);
      if (is_undo) undo_req = 1'b1; else move_req = 1'b1;
      cursor = cur;
      @(negedge clk);
      undo_req = 1'b0; move_req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (done === 1'b1) begin
            n_done++;
            if (got_lat == 0) begin got_lat = i; got_ok = ok; end
         end
         if (i < 4) @(negedge clk);
      end
      checks++;
      if (got_lat != exp_lat || n_done != (exp_lat != 0 ? 1 : 0)) begin
         failures++;
         $display("FAIL req_done undo=%0d cur=%o latency=%0d pulses=%0d want latency=%0d",
                  is_undo, cur, got_lat, n_done, exp_lat);
      end
      checks++;
      if (exp_lat != 0 && got_ok != exp_ok) begin
         failures++;
         $display("FAIL req_ok undo=%0d cur=%o got=%0d want=%0d", is_undo, cur, got_ok, exp_ok);
      end
      checks++;
      if (game_state !== m_state || step_count !== SW'(m_step) || won !== m_won) begin
         failures++;
         $display("FAIL req_state state=%h step=%0d won=%b want state=%h step=%0d won=%b",
                  game_state, step_count, won, m_state, m_step, m_won);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (game_state !== '0 || step_count !== '0 || done !== 1'b0 || ok !== 1'b0 ||
          won !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_values state=%h step=%0d done=%b ok=%b won=%b busy=%b want all zero",
                  game_state, step_count, done, ok, won, busy);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_move_basic;
      do_load(mk(ALL, 64'h0, 2, 2), 64'h1);
      do_req(0, 6'o00);
      checks++;
      if (game_state[5:0] === 6'o22 || step_count !== SW'(1)) begin
         failures++;
         $display("FAIL move_basic man=%o step=%0d want man!=22 step=1", game_state[5:0], step_count);
      end
   endtask

   task automatic test_undo;
      do_req(1, 6'o00);
      checks++;
      if (game_state !== mk(ALL, 64'h0, 2, 2) || step_count !== SW'(0)) begin
         failures++;
         $display("FAIL undo_restore state=%h step=%0d want loaded state step=0", game_state, step_count);
      end
      do_req(1, 6'o00);
   endtask

   task automatic test_reject;
      do_load(mk(64'h0, 64'h0, 3, 3), 64'h1);
      do_req(0, 6'o55);
      do_req(0, 6'o33);
   endtask

   task automatic test_won;
      do_load(mk(ALL, 64'h0000_0000_0010_0000, 1, 1), 64'h0000_0000_0010_0000);
      checks++;
      if (won !== 1'b1) begin
         failures++;
         $display("FAIL won_set got=%b want=1", won);
      end
      do_req(0, 6'o13);
      do_req(1, 6'o00);
   endtask

   task automatic test_priority;
      logic [133:0] s2;
      int nd;
      do_load(mk(ALL, 64'h0, 3, 3), 64'h0);
      do_req(0, 6'o30);
      s2 = mk(ALL, 64'h0000_0000_0000_0400, 4, 4);
      @(negedge clk);
      level_load = 1'b1; level_state = s2; level_goal = 64'h0;
      undo_req = 1'b1; move_req = 1'b1; cursor = 6'o40;
      @(negedge clk);
      level_load = 1'b0; undo_req = 1'b0; move_req = 1'b0;
      nd = 0;
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) nd++;
         @(negedge clk);
      end
      m_state = s2; m_goal = 64'h0; m_snap_v = 0; m_step = 0; m_won = 0;
      checks++;
      if (nd != 0 || game_state !== s2 || step_count !== SW'(0)) begin
         failures++;
         $display("FAIL priority_load pulses=%0d state=%h step=%0d want pulses=0 state=%h step=0",
                  nd, game_state, step_count, s2);
      end
      do_req(1, 6'o00);
   endtask

   task automatic test_load_in_eval;
      logic [133:0] s2;
      int nd;
      do_load(mk(ALL, 64'h0, 3, 3), 64'h0);
      do_req(0, 6'o35);
      s2 = mk(ALL, 64'h0, 5, 5);
      @(negedge clk);
      move_req = 1'b1; cursor = 6'o30;
      @(negedge clk);
      move_req = 1'b0;
      level_load = 1'b1; level_state = s2; level_goal = 64'h0;
      @(negedge clk);
      level_load = 1'b0;
      nd = 0;
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) nd++;
         @(negedge clk);
      end
      m_state = s2; m_goal = 64'h0; m_snap_v = 0; m_step = 0; m_won = 0;
      checks++;
      if (nd != 0 || game_state !== s2 || step_count !== SW'(0)) begin
         failures++;
         $display("FAIL load_in_eval pulses=%0d state=%h step=%0d want pulses=0 state=%h step=0",
                  nd, game_state, step_count, s2);
      end
   endtask

   task automatic test_saturate;
      do_load(mk(ALL, 64'h0, 3, 3), 64'h0);
      for (int i = 0; i < 10; i++) do_req(0, (i % 2 == 0) ? 6'o30 : 6'o37);
      checks++;
      if (step_count !== SW'(SMAX)) begin
         failures++;
         $display("FAIL step_saturate got=%0d want=%0d", step_count, SMAX);
      end
      do_req(1, 6'o00);
   endtask

   task automatic test_random;
      logic [63:0] w, b, g;
      int y, x, op;
      for (int n = 0; n < 150; n++) begin
         op = int'($urandom_range(0, 9));
         if (n == 0 || op == 0) begin
            y = int'($urandom_range(1, 6)); x = int'($urandom_range(1, 6));
            w = {$urandom, $urandom} | {$urandom, $urandom};
            b = w & {$urandom, $urandom} & {$urandom, $urandom};
            w[y*8+x] = 1'b1; b[y*8+x] = 1'b0;
            if ($urandom_range(0, 3) == 0) g = b;
            else g = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            do_load(mk(w, b, y, x), g);
         end else if (op <= 3) begin
            do_req(1, 6'o00);
         end else if (op == 4) begin
            do_req(0, m_state[5:0]);
         end else begin
            do_req(0, 6'($urandom));
         end
      end
   endtask

   task automatic test_async_reset;
      do_load(mk(ALL, 64'h0, 3, 3), 64'h0);
      @(negedge clk);
      move_req = 1'b1; cursor = 6'o30;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (game_state !== '0 || step_count !== '0 || done !== 1'b0 || ok !== 1'b0 ||
          won !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset state=%h step=%0d done=%b ok=%b won=%b busy=%b want all zero",
                  game_state, step_count, done, ok, won, busy);
      end
      move_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || game_state !== '0 || step_count !== '0) begin
            failures++;
            $display("FAIL reset_no_commit done=%b state=%h step=%0d want 0 0 0",
                     done, game_state, step_count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_move_basic();
      test_undo();
      test_reject();
      test_won();
      test_priority();
      test_load_in_eval();
      test_saturate();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
